robot_drive_fsm: RTL and testbench
==================================

// Module: robot_drive_fsm
// PURPOSE
//  Parametrised successor to the two-sensor synchronous robot control FSM.
//  Debounces S1/S2 and drives forward motion with a ramped PWM duty.
//  Enforces a minimum brake hold time and adds an optional timed reverse manoeuvre.
//  Sits between the raw proximity sensors and the motor driver stage.
// PARAMETERS
//  DEBOUNCE        4    consecutive differing samples before a filtered sensor changes (>=1)
//  BRAKE_HOLD      8    minimum cycles spent in BRAKE (>=1)
//  REVERSE_CYCLES  16   cycles spent in REVERSE (>=1)
//  PWM_W           8    PWM counter / duty width
//  RAMP_STEP       32   duty increment per cycle in DRIVE
//  REV_DUTY        128  fixed duty used in REVERSE
//  EN_REVERSE      1    1: sustained 11 after brake hold enters REVERSE; 0: stay in BRAKE
// PORTS
//  clk       in   1      clock; all logic on rising edge
//  reset     in   1      synchronous, active-high reset
//  enable    in   1      1: motion permitted
//  S1        in   1      proximity sensor 1 (raw)
//  S2        in   1      proximity sensor 2 (raw)
//  max_duty  in   PWM_W  forward duty ceiling
//  Z1        out  1      forward drive PWM
//  Z2        out  1      brake
//  Z3        out  1      reverse drive PWM
//  state_o   out  2      0 IDLE, 1 DRIVE, 2 BRAKE, 3 REVERSE
//  duty_o    out  PWM_W  current duty register
// BEHAVIOUR
//  Reset (sync): state=IDLE; duty=0; pwm_cnt=0; filtered sensors=0; all counters=0.
//   All outputs read 0 in the cycle after the reset edge.
//  Outputs are Moore: decoded from registered state/duty/pwm_cnt only; no input-to-output path.
//  Debounce, per sensor:
//   - Any edge with raw!=filt increments db_cnt.
//   - Any edge with raw==filt clears db_cnt.
//   - When raw!=filt and db_cnt==DEBOUNCE-1: filt<=raw and db_cnt<=0.
//   - Raw stable from edge k: filt changes at edge k+DEBOUNCE-1; state reacts one edge later.
//  c={S1f,S2f}. Transitions evaluated every edge:
//   IDLE:
//    - enable=0: stay.
//    - c=01/10: DRIVE.
//    - c=11: BRAKE.
//    - c=00: stay.
//   DRIVE:
//    - enable=0 or c=11: BRAKE.
//    - c=00: IDLE.
//    - c=01/10: stay.
//   BRAKE, hold_cnt cleared on entry:
//    - While hold_cnt<BRAKE_HOLD-1: stay, hold_cnt++.
//    - Once hold_cnt==BRAKE_HOLD-1 (exactly BRAKE_HOLD cycles spent), evaluate exits in priority order:
//      enable=0 or c=00: IDLE; c=01/10: DRIVE; c=11 with EN_REVERSE=1: REVERSE; c=11 with EN_REVERSE=0: stay.
//   REVERSE, rev_cnt cleared on entry:
//    - enable=0: BRAKE immediately.
//    - After REVERSE_CYCLES cycles: BRAKE (new hold).
//  Duty:
//   - Entry to DRIVE sets duty=0.
//   - In DRIVE, each edge: duty<=min(duty+RAMP_STEP, max_duty), computed PWM_W+1 wide (no wrap).
//   - max_duty lowered below duty: clamps on next edge.
//   - Entry to REVERSE: duty=REV_DUTY. IDLE/BRAKE: duty=0.
//  PWM:
//   - pwm_cnt free-runs and wraps at 2^PWM_W.
//   - Z1=(state==DRIVE)&&(pwm_cnt<duty).
//   - Z3=(state==REVERSE)&&(pwm_cnt<duty).
//   - Z2=(state==BRAKE).
//   - Duty 0: never high; duty 2^PWM_W-1: low one cycle per period.
//  Invariant: at most one of Z1/Z2/Z3 is high in any cycle.
//  Reset mid-operation: overrides everything; debounce history discarded.
// TESTING (defaults)
//  1. Reset held 3 cycles, S1=S2=1 -> all outputs 0, state_o=0; remains IDLE 4+ cycles after release, then BRAKE.
//  2. S2=1 for 3 cycles then 0 -> state stays IDLE. S2=1 held from edge k -> DRIVE at edge k+4.
//  3. DRIVE with max_duty=100 -> duty_o 0,32,64,96,100,100; Z1 high exactly 100 of each 256-cycle window.
//  4. c=11 in DRIVE, then c=01 next cycle -> Z2 high exactly 8 cycles, then DRIVE with duty_o=0.
//  5. c=11 held, EN_REVERSE=1 -> BRAKE 8, REVERSE 16 (Z3 high 128/256), BRAKE 8, repeat. EN_REVERSE=0 -> BRAKE indefinitely.
//  6. enable=0 in DRIVE -> BRAKE next edge, IDLE 8 cycles later. reset asserted in REVERSE -> IDLE, all outputs 0 after that edge.

Source files
------------

// File: rtl/robot_drive_fsm.sv
// Two-sensor robot drive controller: debounced sensors, ramped forward PWM,
// minimum brake hold and an optional timed reverse manoeuvre.
module robot_drive_fsm #(
  parameter int unsigned DEBOUNCE       = 4,
  parameter int unsigned BRAKE_HOLD     = 8,
  parameter int unsigned REVERSE_CYCLES = 16,
  parameter int unsigned PWM_W          = 8,
  parameter int unsigned RAMP_STEP      = 32,
  parameter int unsigned REV_DUTY       = 128,
  parameter bit          EN_REVERSE     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             S1,
  input  logic             S2,
  input  logic [PWM_W-1:0] max_duty,
  output logic             Z1,
  output logic             Z2,
  output logic             Z3,
  output logic [1:0]       state_o,
  output logic [PWM_W-1:0] duty_o
);

  localparam int unsigned DbW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned HoldW = (BRAKE_HOLD > 1) ? $clog2(BRAKE_HOLD) : 1;
  localparam int unsigned RevW  = (REVERSE_CYCLES > 1) ? $clog2(REVERSE_CYCLES) : 1;

  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(BRAKE_HOLD - 1);
  localparam logic [RevW-1:0]  RevLast  = RevW'(REVERSE_CYCLES - 1);
  localparam logic [PWM_W:0]   RampStep = (PWM_W + 1)'(RAMP_STEP);
  localparam logic [PWM_W-1:0] RevDuty  = PWM_W'(REV_DUTY);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StDrive   = 2'd1,
    StBrake   = 2'd2,
    StReverse = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [RevW-1:0]  rev_q, rev_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [PWM_W-1:0] pwm_q;
  logic [PWM_W:0]   duty_sum;

  logic [1:0]     raw;
  logic [1:0]     filt_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic           hold_done, rev_done;

  // Bit 1 is S1, bit 0 is S2, so filt_q is the condition code c directly.
  assign raw       = {S1, S2};
  assign hold_done = (hold_q == HoldLast);
  assign rev_done  = (rev_q == RevLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q      <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          filt_q[i]   <= raw[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      hold_q  <= '0;
      rev_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rev_q   <= rev_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_q + PWM_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (enable) begin
          if (filt_q == 2'b11)      state_d = StBrake;
          else if (filt_q != 2'b00) state_d = StDrive;
        end
      end
      StDrive: begin
        if (!enable || filt_q == 2'b11) state_d = StBrake;
        else if (filt_q == 2'b00)       state_d = StIdle;
      end
      StBrake: begin
        if (hold_done) begin
          if (!enable || filt_q == 2'b00) state_d = StIdle;
          else if (filt_q != 2'b11)       state_d = StDrive;
          else if (EN_REVERSE)            state_d = StReverse;
        end
      end
      StReverse: begin
        if (!enable || rev_done) state_d = StBrake;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counters and duty restart whenever a state is entered from elsewhere.
  always_comb begin
    hold_d   = '0;
    rev_d    = '0;
    duty_d   = '0;
    duty_sum = {1'b0, duty_q} + RampStep;
    if (state_d == StBrake && state_q == StBrake) begin
      hold_d = hold_done ? hold_q : hold_q + HoldW'(1);
    end
    if (state_d == StReverse && state_q == StReverse) begin
      rev_d = rev_q + RevW'(1);
    end
    case (state_d)
      StDrive: begin
        if (state_q == StDrive) begin
          duty_d = (duty_sum > {1'b0, max_duty}) ? max_duty : duty_sum[PWM_W-1:0];
        end
      end
      StReverse: duty_d = RevDuty;
      default:   duty_d = '0;
    endcase
  end

  always_comb begin
    Z1      = (state_q == StDrive) && (pwm_q < duty_q);
    Z2      = (state_q == StBrake);
    Z3      = (state_q == StReverse) && (pwm_q < duty_q);
    state_o = state_q;
    duty_o  = duty_q;
  end

endmodule

// File: tb/tb_robot_drive_fsm.sv
// Scoreboard bench for robot_drive_fsm: each step queues inputs plus expected
// state/duty; Z outputs are derived from the expectation and a PWM phase model.
module tb_robot_drive_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       S1 = 1'b0;
  logic       S2 = 1'b0;
  logic [7:0] max_duty = 8'd100;
  logic       Z1, Z2, Z3;
  logic [1:0] state_o;
  logic [7:0] duty_o;
  logic       nr_z1, nr_z2, nr_z3;
  logic [1:0] nr_state;
  logic [7:0] nr_duty;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] pwm_m;

  typedef struct {
    logic       rst;
    logic       en;
    logic       s1;
    logic       s2;
    logic [7:0] md;
    logic [1:0] st;
    logic [7:0] duty;
  } step_t;

  step_t sb[$];

  robot_drive_fsm dut (
    .clk(clk), .reset(reset), .enable(enable), .S1(S1), .S2(S2), .max_duty(max_duty),
    .Z1(Z1), .Z2(Z2), .Z3(Z3), .state_o(state_o), .duty_o(duty_o)
  );

  robot_drive_fsm #(.EN_REVERSE(1'b0)) dut_nr (
    .clk(clk), .reset(reset), .enable(enable), .S1(S1), .S2(S2), .max_duty(max_duty),
    .Z1(nr_z1), .Z2(nr_z2), .Z3(nr_z3), .state_o(nr_state), .duty_o(nr_duty)
  );

  always #5 clk = ~clk;

  // Free-running PWM phase as seen after each edge.
  always @(posedge clk) pwm_m <= reset ? 8'd0 : pwm_m + 8'd1;

  function automatic logic [2:0] exp_z(input logic [1:0] st, input logic [7:0] d);
    return {(st == 2'd1) && (pwm_m < d), st == 2'd2, (st == 2'd3) && (pwm_m < d)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rst, input logic en, input logic s1, input logic s2,
                      input logic [7:0] md, input logic [1:0] st, input logic [7:0] duty,
                      input int n);
    for (int i = 0; i < n; i++) sb.push_back('{rst, en, s1, s2, md, st, duty});
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; S1 = 1'b0; S2 = 1'b0; max_duty = 8'd100;
    tick();
    tick();
  endtask

  task automatic test_reset();
    step_t s;
    int idx = 0;
    push(1, 1, 1, 1, 100, 0, 0, 3);
    push(0, 1, 1, 1, 100, 0, 0, 4);
    push(0, 1, 1, 1, 100, 2, 0, 3);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      reset = s.rst; enable = s.en; S1 = s.s1; S2 = s.s2; max_duty = s.md;
      tick();
      n_tests++;
      if (state_o !== s.st || duty_o !== s.duty || {Z1, Z2, Z3} !== exp_z(s.st, s.duty)) begin
        n_fail++;
        $display("FAIL reset step %0d: got state=%0d duty=%0d z=%b, want state=%0d duty=%0d z=%b",
                 idx, state_o, duty_o, {Z1, Z2, Z3}, s.st, s.duty, exp_z(s.st, s.duty));
      end
      idx++;
    end
  endtask

  task automatic test_debounce();
    step_t s;
    int idx = 0;
    do_reset();
    push(0, 1, 0, 1, 100, 0, 0, 3);  // glitch shorter than the debounce window
    push(0, 1, 0, 0, 100, 0, 0, 4);
    push(0, 1, 0, 1, 100, 0, 0, 4);
    push(0, 1, 0, 1, 100, 1, 0, 1);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      reset = s.rst; enable = s.en; S1 = s.s1; S2 = s.s2; max_duty = s.md;
      tick();
      n_tests++;
      if (state_o !== s.st || duty_o !== s.duty || {Z1, Z2, Z3} !== exp_z(s.st, s.duty)) begin
        n_fail++;
        $display("FAIL debounce step %0d: got state=%0d duty=%0d z=%b, want state=%0d duty=%0d z=%b",
                 idx, state_o, duty_o, {Z1, Z2, Z3}, s.st, s.duty, exp_z(s.st, s.duty));
      end
      idx++;
    end
  endtask

  task automatic test_ramp();
    step_t s;
    int idx = 0;
    int z1_cnt = 0;
    push(0, 1, 0, 1, 100, 1, 32, 1);
    push(0, 1, 0, 1, 100, 1, 64, 1);
    push(0, 1, 0, 1, 100, 1, 96, 1);
    push(0, 1, 0, 1, 100, 1, 100, 2);
    push(0, 1, 0, 1, 100, 1, 100, 256);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      reset = s.rst; enable = s.en; S1 = s.s1; S2 = s.s2; max_duty = s.md;
      tick();
      n_tests++;
      if (state_o !== s.st || duty_o !== s.duty || {Z1, Z2, Z3} !== exp_z(s.st, s.duty)) begin
        n_fail++;
        $display("FAIL ramp step %0d: got state=%0d duty=%0d z=%b, want state=%0d duty=%0d z=%b",
                 idx, state_o, duty_o, {Z1, Z2, Z3}, s.st, s.duty, exp_z(s.st, s.duty));
      end
      if (idx >= 5 && Z1 === 1'b1) z1_cnt++;
      idx++;
    end
    n_tests++;
    if (z1_cnt !== 100) begin
      n_fail++;
      $display("FAIL ramp_window: Z1 high %0d of 256 cycles, want 100", z1_cnt);
    end
  endtask

  task automatic test_brake_release();
    step_t s;
    int idx = 0;
    int z2_cnt = 0;
    push(0, 1, 1, 1, 100, 1, 100, 4);
    push(0, 1, 0, 1, 100, 2, 0, 8);
    push(0, 1, 0, 1, 100, 1, 0, 1);
    push(0, 1, 0, 1, 100, 1, 32, 1);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      reset = s.rst; enable = s.en; S1 = s.s1; S2 = s.s2; max_duty = s.md;
      tick();
      n_tests++;
      if (state_o !== s.st || duty_o !== s.duty || {Z1, Z2, Z3} !== exp_z(s.st, s.duty)) begin
        n_fail++;
        $display("FAIL brake_release step %0d: got state=%0d duty=%0d z=%b, want state=%0d duty=%0d z=%b",
                 idx, state_o, duty_o, {Z1, Z2, Z3}, s.st, s.duty, exp_z(s.st, s.duty));
      end
      if (Z2 === 1'b1) z2_cnt++;
      idx++;
    end
    n_tests++;
    if (z2_cnt !== 8) begin
      n_fail++;
      $display("FAIL brake_hold: Z2 high %0d cycles, want 8", z2_cnt);
    end
  endtask

  task automatic test_reverse();
    step_t s;
    int idx = 0;
    logic [1:0] nr_exp;
    push(0, 1, 1, 1, 100, 1, 64, 1);
    push(0, 1, 1, 1, 100, 1, 96, 1);
    push(0, 1, 1, 1, 100, 1, 100, 2);
    push(0, 1, 1, 1, 100, 2, 0, 8);
    push(0, 1, 1, 1, 100, 3, 128, 16);
    push(0, 1, 1, 1, 100, 2, 0, 8);
    push(0, 1, 1, 1, 100, 3, 128, 4);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      reset = s.rst; enable = s.en; S1 = s.s1; S2 = s.s2; max_duty = s.md;
      tick();
      n_tests++;
      if (state_o !== s.st || duty_o !== s.duty || {Z1, Z2, Z3} !== exp_z(s.st, s.duty)) begin
        n_fail++;
        $display("FAIL reverse step %0d: got state=%0d duty=%0d z=%b, want state=%0d duty=%0d z=%b",
                 idx, state_o, duty_o, {Z1, Z2, Z3}, s.st, s.duty, exp_z(s.st, s.duty));
      end
      nr_exp = (idx < 4) ? 2'd1 : 2'd2;
      n_tests++;
      if (nr_state !== nr_exp || nr_z3 !== 1'b0) begin
        n_fail++;
        $display("FAIL no_reverse step %0d: got state=%0d z3=%b, want state=%0d z3=0",
                 idx, nr_state, nr_z3, nr_exp);
      end
      idx++;
    end
  endtask

  task automatic test_full_duty();
    step_t s;
    int idx = 0;
    int z1_cnt = 0;
    do_reset();
    push(0, 1, 0, 1, 255, 0, 0, 4);
    push(0, 1, 0, 1, 255, 1, 0, 1);
    for (int k = 1; k <= 7; k++) push(0, 1, 0, 1, 255, 1, 8'(32 * k), 1);
    push(0, 1, 0, 1, 255, 1, 255, 1);
    push(0, 1, 0, 1, 255, 1, 255, 256);
    push(0, 1, 0, 1, 50, 1, 50, 2);  // ceiling lowered below current duty
    while (sb.size() > 0) begin
      s = sb.pop_front();
      reset = s.rst; enable = s.en; S1 = s.s1; S2 = s.s2; max_duty = s.md;
      tick();
      n_tests++;
      if (state_o !== s.st || duty_o !== s.duty || {Z1, Z2, Z3} !== exp_z(s.st, s.duty)) begin
        n_fail++;
        $display("FAIL full_duty step %0d: got state=%0d duty=%0d z=%b, want state=%0d duty=%0d z=%b",
                 idx, state_o, duty_o, {Z1, Z2, Z3}, s.st, s.duty, exp_z(s.st, s.duty));
      end
      if (idx >= 13 && idx < 269 && Z1 === 1'b1) z1_cnt++;
      idx++;
    end
    n_tests++;
    if (z1_cnt !== 255) begin
      n_fail++;
      $display("FAIL full_duty_window: Z1 high %0d of 256 cycles, want 255", z1_cnt);
    end
  endtask

  task automatic test_enable();
    step_t s;
    int idx = 0;
    do_reset();
    push(0, 1, 0, 1, 100, 0, 0, 4);
    push(0, 1, 0, 1, 100, 1, 0, 1);
    push(0, 1, 0, 1, 100, 1, 32, 1);
    push(0, 0, 0, 1, 100, 2, 0, 8);
    push(0, 0, 0, 1, 100, 0, 0, 2);
    push(0, 1, 0, 1, 100, 1, 0, 1);
    push(0, 1, 0, 1, 100, 1, 32, 1);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      reset = s.rst; enable = s.en; S1 = s.s1; S2 = s.s2; max_duty = s.md;
      tick();
      n_tests++;
      if (state_o !== s.st || duty_o !== s.duty || {Z1, Z2, Z3} !== exp_z(s.st, s.duty)) begin
        n_fail++;
        $display("FAIL enable step %0d: got state=%0d duty=%0d z=%b, want state=%0d duty=%0d z=%b",
                 idx, state_o, duty_o, {Z1, Z2, Z3}, s.st, s.duty, exp_z(s.st, s.duty));
      end
      idx++;
    end
  endtask

  task automatic test_reverse_abort_reset();
    step_t s;
    int idx = 0;
    do_reset();
    push(0, 1, 1, 1, 100, 0, 0, 4);
    push(0, 1, 1, 1, 100, 2, 0, 8);
    push(0, 1, 1, 1, 100, 3, 128, 1);
    push(0, 0, 1, 1, 100, 2, 0, 8);    // enable dropped in REVERSE
    push(0, 0, 1, 1, 100, 0, 0, 1);
    push(0, 1, 1, 1, 100, 2, 0, 8);
    push(0, 1, 1, 1, 100, 3, 128, 2);
    push(1, 1, 1, 1, 100, 0, 0, 1);    // reset mid-REVERSE
    push(0, 1, 1, 1, 100, 0, 0, 4);
    push(0, 1, 1, 1, 100, 2, 0, 1);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      reset = s.rst; enable = s.en; S1 = s.s1; S2 = s.s2; max_duty = s.md;
      tick();
      n_tests++;
      if (state_o !== s.st || duty_o !== s.duty || {Z1, Z2, Z3} !== exp_z(s.st, s.duty)) begin
        n_fail++;
        $display("FAIL reverse_abort step %0d: got state=%0d duty=%0d z=%b, want state=%0d duty=%0d z=%b",
                 idx, state_o, duty_o, {Z1, Z2, Z3}, s.st, s.duty, exp_z(s.st, s.duty));
      end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_ramp();
    test_brake_release();
    test_reverse();
    test_full_duty();
    test_enable();
    test_reverse_abort_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
